// File: rtl/assert_event_log.sv
// Assertion-failure event log: FIFO of {id, data, timestamp} with drop counter.
// Optional cycle timestamps enabled by defining ASSERT_EVENT_LOG_TIMESTAMP_EN.
module assert_event_log #(
    parameter int DEPTH  = 8,
    parameter int ID_W   = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              chk_valid,
    input  logic [ID_W-1:0]   chk_id,
    input  logic [DATA_W-1:0] chk_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [ID_W-1:0]   rd_id,
    output logic [DATA_W-1:0] rd_data,
    output logic [31:0]       rd_ts,
    output logic [15:0]       drop_cnt,
    output logic              halt,
    output logic [ID_W-1:0]   first_id
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic [15:0]       drop_q, drop_d;
    logic              halt_q, halt_d;
    logic [ID_W-1:0]   first_q, first_d;

    logic [ID_W-1:0]   id_mem_q   [DEPTH];
    logic [DATA_W-1:0] data_mem_q [DEPTH];

    logic empty, full, push, pop, drop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // Handshake decode; a pop frees a slot for a same-cycle push when full
    always_comb begin
        pop      = !rst && !empty && rd_ready;
        push     = !rst && chk_valid && (!full || pop);
        drop     = !rst && chk_valid && full && !pop;
        wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        drop_d   = drop_q;
        if (drop && drop_q != 16'hFFFF) begin
            drop_d = drop_q + 16'd1;
        end
        halt_d  = halt_q;
        first_d = first_q;
        if (chk_valid && !halt_q) begin
            halt_d  = 1'b1;
            first_d = chk_id;
        end
    end

    // Control state with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            drop_q   <= '0;
            halt_q   <= 1'b0;
            first_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            drop_q   <= drop_d;
            halt_q   <= halt_d;
            first_q  <= first_d;
        end
    end

    // Entry storage; contents are masked at the output when empty
    always_ff @(posedge clk) begin
        if (push) begin
            id_mem_q[wr_ptr_q[AW-1:0]]   <= chk_id;
            data_mem_q[wr_ptr_q[AW-1:0]] <= chk_data;
        end
    end

`ifdef ASSERT_EVENT_LOG_TIMESTAMP_EN
    logic [31:0] cnt_q;
    logic [31:0] ts_mem_q [DEPTH];

    // Free-running cycle counter, zero on the first cycle after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    // Timestamp storage alongside the entry
    always_ff @(posedge clk) begin
        if (push) begin
            ts_mem_q[wr_ptr_q[AW-1:0]] <= cnt_q;
        end
    end

    assign rd_ts = rd_valid ? ts_mem_q[rd_ptr_q[AW-1:0]] : '0;
`else
    assign rd_ts = '0;
`endif

    assign rd_valid = !empty;
    assign rd_id    = rd_valid ? id_mem_q[rd_ptr_q[AW-1:0]] : '0;
    assign rd_data  = rd_valid ? data_mem_q[rd_ptr_q[AW-1:0]] : '0;
    assign drop_cnt = drop_q;
    assign halt     = halt_q;
    assign first_id = first_q;

endmodule

// File: tb/tb_assert_event_log.sv
// Directed bench for assert_event_log with immediate-assertion checks.
// Expected timestamps follow ASSERT_EVENT_LOG_TIMESTAMP_EN when defined.
module tb_assert_event_log;

    localparam int DEPTH = 8;
`ifdef ASSERT_EVENT_LOG_TIMESTAMP_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        chk_valid;
    logic [7:0]  chk_id;
    logic [31:0] chk_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [7:0]  rd_id;
    logic [31:0] rd_data;
    logic [31:0] rd_ts;
    logic [15:0] drop_cnt;
    logic        halt;
    logic [7:0]  first_id;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0]  id;
        logic [31:0] data;
        logic [31:0] ts;
    } ent_t;

    ent_t q[$];

    assert_event_log #(.DEPTH(DEPTH), .ID_W(8), .DATA_W(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .chk_valid(chk_valid),
        .chk_id   (chk_id),
        .chk_data (chk_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_id    (rd_id),
        .rd_data  (rd_data),
        .rd_ts    (rd_ts),
        .drop_cnt (drop_cnt),
        .halt     (halt),
        .first_id (first_id)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ets(input int c);
        return TS_EN ? 32'(c) : 32'd0;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        chk_valid = 1'b0;
        rd_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        int reads;
        int drops;
        int cyc;
        bit pop_m;
        bit acc_m;
        rst = 1'b1;
        chk_valid = 1'b0;
        chk_id = '0;
        chk_data = '0;
        rd_ready = 1'b0;
        step();
        step();

        // Reset state, then first event on the first non-reset cycle
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_halt", halt, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_first_id", first_id, 0);
        chk("rst_rd_id_zero", rd_id, 0);
        chk("rst_rd_data_zero", rd_data, 0);
        rst = 1'b0;
        chk_valid = 1'b1;
        chk_id = 8'h05;
        chk_data = 32'hDEADBEEF;
        chk("no_bypass", rd_valid, 0);
        step();
        chk_valid = 1'b0;
        chk("first_rd_valid", rd_valid, 1);
        chk("first_rd_id", rd_id, 8'h05);
        chk("first_rd_data", rd_data, 32'hDEADBEEF);
        chk("first_rd_ts", rd_ts, 0);
        chk("first_halt", halt, 1);
        chk("first_first_id", first_id, 8'h05);
        step();
        chk("hold_rd_id", rd_id, 8'h05);
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        chk("pop_empty", rd_valid, 0);
        chk("pop_zero_data", rd_data, 0);
        chk("halt_sticky", halt, 1);

        // Ten back-to-back events into an 8-deep log
        do_reset();
        for (int i = 0; i < 10; i++) begin
            chk_valid = 1'b1;
            chk_id = 8'h10 + 8'(i);
            chk_data = 32'h100 * 32'(i);
            step();
        end
        chk_valid = 1'b0;
        chk("fill_drop", drop_cnt, 2);
        chk("fill_first_id", first_id, 8'h10);
        chk("fill_head", rd_id, 8'h10);
        rd_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("fill_valid", rd_valid, 1);
            chk("fill_id", rd_id, 8'h10 + 8'(i));
            chk("fill_data", rd_data, 32'h100 * 32'(i));
            chk("fill_ts", rd_ts, ets(i));
            step();
        end
        rd_ready = 1'b0;
        chk("fill_drained", rd_valid, 0);
        chk("fill_drop_kept", drop_cnt, 2);

        // Full log with coincident push and pop
        do_reset();
        for (int i = 0; i < 8; i++) begin
            chk_valid = 1'b1;
            chk_id = 8'h20 + 8'(i);
            chk_data = 32'h2000 + 32'(i);
            step();
        end
        chk_id = 8'h0A;
        chk_data = 32'h0000_0A0A;
        rd_ready = 1'b1;
        chk("full_head", rd_id, 8'h20);
        step();
        chk_valid = 1'b0;
        chk("full_drop", drop_cnt, 0);
        for (int i = 1; i < 8; i++) begin
            chk("full_id", rd_id, 8'h20 + 8'(i));
            chk("full_ts", rd_ts, ets(i));
            step();
        end
        chk("full_last_id", rd_id, 8'h0A);
        chk("full_last_data", rd_data, 32'h0000_0A0A);
        chk("full_last_ts", rd_ts, ets(8));
        step();
        rd_ready = 1'b0;
        chk("full_empty", rd_valid, 0);

        // Reset mid-use discards entries and ignores inputs
        do_reset();
        for (int i = 0; i < 3; i++) begin
            chk_valid = 1'b1;
            chk_id = 8'h40 + 8'(i);
            chk_data = 32'(i);
            step();
        end
        rst = 1'b1;
        chk_id = 8'h77;
        rd_ready = 1'b1;
        step();
        rst = 1'b0;
        rd_ready = 1'b0;
        chk("mid_rd_valid", rd_valid, 0);
        chk("mid_halt", halt, 0);
        chk("mid_drop", drop_cnt, 0);
        chk("mid_first_id", first_id, 0);
        chk_id = 8'h33;
        chk_data = 32'h1234_5678;
        step();
        chk_valid = 1'b0;
        chk("post_rd_id", rd_id, 8'h33);
        chk("post_rd_data", rd_data, 32'h1234_5678);
        chk("post_rd_ts", rd_ts, 0);
        chk("post_first_id", first_id, 8'h33);

        // Random reader against a queue model over 100 events
        do_reset();
        q.delete();
        reads = 0;
        drops = 0;
        cyc = 0;
        for (int k = 0; k < 130; k++) begin
            chk("rnd_valid", rd_valid, q.size() > 0);
            if (q.size() > 0) begin
                chk("rnd_id", rd_id, q[0].id);
                chk("rnd_data", rd_data, q[0].data);
                chk("rnd_ts", rd_ts, q[0].ts);
            end
            chk_valid = (k < 100);
            chk_id = 8'(k);
            chk_data = 32'hA000_0000 + 32'(k);
            rd_ready = (k < 100) ? 1'($urandom_range(0, 1)) : 1'b1;
            pop_m = (q.size() > 0) && rd_ready;
            acc_m = chk_valid && ((q.size() < DEPTH) || pop_m);
            if (pop_m) begin
                void'(q.pop_front());
                reads++;
            end
            if (chk_valid && !acc_m) drops++;
            if (acc_m) q.push_back('{chk_id, chk_data, ets(cyc)});
            step();
            cyc++;
        end
        chk_valid = 1'b0;
        rd_ready = 1'b0;
        chk("rnd_empty", rd_valid, 0);
        chk("rnd_drop", drop_cnt, 16'(drops));
        chk("rnd_count", 100 - drop_cnt, reads);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
